trigger_buffer_ctrl: RTL and testbench

Parametrised successor to the single-channel buffer controller. It arms on a PC request and captures pre-trigger and post-trigger samples into a circular sample RAM. Features: N ADC channels, selectable trigger channel and edge (rising, falling or either), single or auto mode, a parametrised auto timeout, a software force-trigger, and a latched trigger address so readout can locate the trigger point. It sits between the ADC controller, the RAM controller, the configuration controller and the PC communication controller.

---
 rtl/trigger_pkg.sv | 18 +
 rtl/trig_edge_det.sv | 46 ++++
 rtl/trigger_buffer_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_trigger_buffer_ctrl.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/trigger_pkg.sv
// Shared encodings for the trigger buffer controller and its edge detector.
package trigger_pkg;

  typedef enum logic [1:0] {
    ST_PRE_LOADING     = 2'b00,
    ST_WAITING_TRIGGER = 2'b01,
    ST_POST_LOADING    = 2'b10,
    ST_SENDING_DATA    = 2'b11
  } state_t;

  localparam logic [1:0] TRIG_EDGE_RISING  = 2'b00;
  localparam logic [1:0] TRIG_EDGE_FALLING = 2'b01;
  localparam logic [1:0] TRIG_EDGE_EITHER  = 2'b10;

  localparam logic CONF_SINGLE = 1'b0;
  localparam logic CONF_AUTO   = 1'b1;

endpackage

// File: rtl/trig_edge_det.sv
// Threshold edge detector; remembers the previous sample and flags a crossing
// on the input_rdy cycle of the crossing sample.
module trig_edge_det
  import trigger_pkg::*;
#(
  parameter int unsigned BITS_ADC = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic [BITS_ADC-1:0] sample,
  input  logic [BITS_ADC-1:0] value,
  input  logic [1:0]          edge_sel,
  input  logic                input_rdy,
  output logic                triggered
);

  logic [BITS_ADC-1:0] prev_q;
  logic                prev_valid_q;
  logic                rise;
  logic                fall;
  logic                hit;

  // History is discarded whenever the detector is disabled
  always_ff @(posedge clk) begin
    if (rst || !enable) begin
      prev_q       <= '0;
      prev_valid_q <= 1'b0;
    end else if (input_rdy) begin
      prev_q       <= sample;
      prev_valid_q <= 1'b1;
    end
  end

  always_comb begin
    rise = (prev_q < value) && (sample >= value);
    fall = (prev_q >= value) && (sample < value);
    case (edge_sel)
      TRIG_EDGE_RISING:  hit = rise;
      TRIG_EDGE_FALLING: hit = fall;
      default:           hit = rise | fall;
    endcase
    triggered = enable && input_rdy && prev_valid_q && hit;
  end

endmodule

// File: rtl/trigger_buffer_ctrl.sv
// Arms on a PC request and captures pre/post-trigger samples into a circular
// sample RAM, latching the trigger address for readout.
module trigger_buffer_ctrl
  import trigger_pkg::*;
#(
  parameter int unsigned BITS_ADC       = 8,
  parameter int unsigned NUM_CH         = 2,
  parameter int unsigned CNT_W          = 16,
  parameter int unsigned AUTO_MULT_LOG2 = 2,
  parameter int unsigned SRC_W          = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_CH*BITS_ADC-1:0] input_sample,
  input  logic                       input_rdy,
  output logic                       write_enable,
  output logic [CNT_W-1:0]           wr_addr,
  output logic [CNT_W-1:0]           trig_addr,
  input  logic                       start,
  input  logic [CNT_W-1:0]           num_samples,
  input  logic [CNT_W-1:0]           pre_trigger,
  input  logic [BITS_ADC-1:0]        trigger_value,
  input  logic [SRC_W-1:0]           trigger_src,
  input  logic [1:0]                 trigger_edge,
  input  logic                       trigger_conf,
  input  logic                       force_trigger,
  output logic                       send_data_rdy,
  input  logic                       send_data_ack,
  output logic                       timed_out
);

  localparam int unsigned CW = CNT_W + AUTO_MULT_LOG2 + 1;

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                request_q, request_d;
  logic [CNT_W-1:0]    wr_addr_d, trig_addr_d;
  logic                send_data_rdy_d, timed_out_d;
  logic [CNT_W-1:0]    ns_q, ns_d, pt_q, pt_d, ns_in, pt_in;
  logic                conf_q, conf_d;
  logic [1:0]          edge_q, edge_d;
  logic [SRC_W-1:0]    src_q, src_d;
  logic [BITS_ADC-1:0] ch_sample;
  logic                det_enable;
  logic                triggered;
  logic [CW-1:0]       auto_limit;
  logic [CW-1:0]       post_target;

  // Sanitised configuration: zero length means one sample, pre-trigger fits inside
  always_comb begin
    ns_in = (num_samples == '0) ? CNT_W'(1) : num_samples;
    pt_in = (pre_trigger >= ns_in) ? ns_in - CNT_W'(1) : pre_trigger;
  end

  // Trigger channel mux; out-of-range selects fall back to channel 0
  always_comb begin
    ch_sample = input_sample[BITS_ADC-1:0];
    for (int k = 0; k < int'(NUM_CH); k++) begin
      if (int'(src_q) == k) ch_sample = input_sample[k*BITS_ADC +: BITS_ADC];
    end
  end

  assign det_enable  = (state_q == ST_WAITING_TRIGGER) && request_q;
  assign auto_limit  = CW'(ns_q) << AUTO_MULT_LOG2;
  assign post_target = CW'(ns_q - pt_q);

  trig_edge_det #(.BITS_ADC(BITS_ADC)) u_edge_det (
    .clk       (clk),
    .rst       (rst),
    .enable    (det_enable),
    .sample    (ch_sample),
    .value     (trigger_value),
    .edge_sel  (edge_q),
    .input_rdy (input_rdy),
    .triggered (triggered)
  );

  always_comb write_enable = (state_q != ST_SENDING_DATA);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_PRE_LOADING;
      cnt_q         <= '0;
      request_q     <= 1'b0;
      wr_addr       <= '0;
      trig_addr     <= '0;
      send_data_rdy <= 1'b0;
      timed_out     <= 1'b0;
      ns_q          <= ns_in;
      pt_q          <= pt_in;
      conf_q        <= trigger_conf;
      edge_q        <= trigger_edge;
      src_q         <= trigger_src;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      request_q     <= request_d;
      wr_addr       <= wr_addr_d;
      trig_addr     <= trig_addr_d;
      send_data_rdy <= send_data_rdy_d;
      timed_out     <= timed_out_d;
      ns_q          <= ns_d;
      pt_q          <= pt_d;
      conf_q        <= conf_d;
      edge_q        <= edge_d;
      src_q         <= src_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    request_d       = request_q | start;
    wr_addr_d       = wr_addr + CNT_W'(input_rdy && write_enable);
    trig_addr_d     = trig_addr;
    send_data_rdy_d = send_data_rdy;
    timed_out_d     = timed_out;
    ns_d            = ns_q;
    pt_d            = pt_q;
    conf_d          = conf_q;
    edge_d          = edge_q;
    src_d           = src_q;

    case (state_q)
      ST_PRE_LOADING: begin
        if (cnt_q == CW'(pt_q)) begin
          cnt_d   = '0;
          state_d = ST_WAITING_TRIGGER;
        end else if (input_rdy) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_WAITING_TRIGGER: begin
        // A real or forced trigger takes priority over the auto timeout
        if (triggered || (force_trigger && request_q)) begin
          trig_addr_d = wr_addr;
          cnt_d       = CW'(1);
          request_d   = 1'b0;
          state_d     = ST_POST_LOADING;
        end else if ((conf_q == CONF_AUTO) && request_q) begin
          if (cnt_q == auto_limit) begin
            trig_addr_d     = wr_addr - CNT_W'(1);
            timed_out_d     = 1'b1;
            send_data_rdy_d = 1'b1;
            cnt_d           = '0;
            request_d       = 1'b0;
            state_d         = ST_SENDING_DATA;
          end else if (input_rdy) begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      ST_POST_LOADING: begin
        if (cnt_q == post_target) begin
          send_data_rdy_d = 1'b1;
          cnt_d           = '0;
          state_d         = ST_SENDING_DATA;
        end else if (input_rdy) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_SENDING_DATA: begin
        if (send_data_ack) begin
          send_data_rdy_d = 1'b0;
          timed_out_d     = 1'b0;
          cnt_d           = '0;
          ns_d            = ns_in;
          pt_d            = pt_in;
          conf_d          = trigger_conf;
          edge_d          = trigger_edge;
          src_d           = trigger_src;
          state_d         = ST_PRE_LOADING;
        end
      end
      default: begin
        cnt_d     = '0;
        request_d = 1'b0;
        state_d   = ST_PRE_LOADING;
      end
    endcase
  end

endmodule

// File: tb/tb_trigger_buffer_ctrl.sv
// Directed bench for trigger_buffer_ctrl: expected trigger addresses are queued
// as stimulus is driven and compared when the capture completes.
module tb_trigger_buffer_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] input_sample = '0;
  logic        input_rdy = 1'b0;
  logic        write_enable;
  logic [15:0] wr_addr;
  logic [15:0] trig_addr;
  logic        start = 1'b0;
  logic [15:0] num_samples = 16'd16;
  logic [15:0] pre_trigger = 16'd4;
  logic [7:0]  trigger_value = 8'h80;
  logic [0:0]  trigger_src = 1'b1;
  logic [1:0]  trigger_edge = 2'b00;
  logic        trigger_conf = 1'b0;
  logic        force_trigger = 1'b0;
  logic        send_data_rdy;
  logic        send_data_ack = 1'b0;
  logic        timed_out;

  typedef struct packed {
    logic [15:0] addr;
    logic        tout;
  } exp_t;

  exp_t        exp_q[$];
  int          total = 0;
  int          bad = 0;
  logic [15:0] wa = '0;

  trigger_buffer_ctrl #(
    .BITS_ADC(8), .NUM_CH(2), .CNT_W(16), .AUTO_MULT_LOG2(2), .SRC_W(1)
  ) dut (
    .clk(clk), .rst(rst), .input_sample(input_sample), .input_rdy(input_rdy),
    .write_enable(write_enable), .wr_addr(wr_addr), .trig_addr(trig_addr),
    .start(start), .num_samples(num_samples), .pre_trigger(pre_trigger),
    .trigger_value(trigger_value), .trigger_src(trigger_src),
    .trigger_edge(trigger_edge), .trigger_conf(trigger_conf),
    .force_trigger(force_trigger), .send_data_rdy(send_data_rdy),
    .send_data_ack(send_data_ack), .timed_out(timed_out)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // One sample strobe followed by an idle cycle
  task automatic send_sample(input logic [7:0] c0, input logic [7:0] c1);
    input_sample = {c1, c0};
    input_rdy    = 1'b1;
    wa           = wa + 16'd1;
    tick();
    input_rdy = 1'b0;
    tick();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic finish_capture(input string tag);
    exp_t e;
    chk({tag, "_rdy"}, 32'(send_data_rdy), 32'd1);
    chk({tag, "_we"}, 32'(write_enable), 32'd0);
    chk({tag, "_wr_addr"}, 32'(wr_addr), 32'(wa));
    chk({tag, "_queued"}, 32'(exp_q.size() != 0), 32'd1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk({tag, "_trig_addr"}, 32'(trig_addr), 32'(e.addr));
      chk({tag, "_timed_out"}, 32'(timed_out), 32'(e.tout));
    end
    // Samples arriving while sending must not move the write pointer
    input_rdy = 1'b1;
    tick();
    input_rdy = 1'b0;
    tick();
    chk({tag, "_hold_addr"}, 32'(wr_addr), 32'(wa));
  endtask

  task automatic ack_capture(input string tag);
    send_data_ack = 1'b1;
    tick();
    send_data_ack = 1'b0;
    chk({tag, "_ack_rdy"}, 32'(send_data_rdy), 32'd0);
    chk({tag, "_ack_tout"}, 32'(timed_out), 32'd0);
    chk({tag, "_ack_we"}, 32'(write_enable), 32'd1);
  endtask

  initial begin
    // Reset with rising edge, ch1, 16 samples, pre 4, single
    repeat (3) tick();
    rst = 1'b0;
    chk("rst_wr_addr", 32'(wr_addr), 32'd0);
    chk("rst_trig_addr", 32'(trig_addr), 32'd0);
    chk("rst_rdy", 32'(send_data_rdy), 32'd0);
    chk("rst_tout", 32'(timed_out), 32'd0);
    chk("rst_we", 32'(write_enable), 32'd1);
    tick();

    // Rising capture
    for (int i = 0; i < 4; i++) send_sample(8'h00, 8'h00);
    send_sample(8'h00, 8'h90);
    send_sample(8'h00, 8'h90);
    pulse_start();
    for (int i = 0; i < 4; i++) send_sample(8'h00, 8'(8'h70 + 4 * i));
    exp_q.push_back('{addr: wa, tout: 1'b0});
    send_sample(8'h00, 8'h80);
    num_samples  = 16'd8;
    trigger_edge = 2'b01;
    for (int i = 0; i < 11; i++) begin
      send_sample(8'h00, 8'(8'h84 + 4 * i));
      if (i == 9) chk("rise_post_early", 32'(send_data_rdy), 32'd0);
    end
    finish_capture("rise");
    num_samples = 16'd16;
    ack_capture("rise");

    // Falling capture on ch1 while ch0 crosses and is ignored
    for (int i = 0; i < 4; i++) send_sample(8'h00, 8'hA0);
    pulse_start();
    send_sample(8'h90, 8'h90);
    send_sample(8'h70, 8'h8C);
    send_sample(8'h70, 8'h88);
    send_sample(8'h70, 8'h84);
    send_sample(8'h70, 8'h80);
    exp_q.push_back('{addr: wa, tout: 1'b0});
    send_sample(8'h70, 8'h7C);
    for (int i = 0; i < 11; i++) begin
      send_sample(8'h70, 8'h70);
      if (i == 9) chk("fall_post_early", 32'(send_data_rdy), 32'd0);
    end
    finish_capture("fall");
    num_samples  = 16'd8;
    pre_trigger  = 16'd0;
    trigger_conf = 1'b1;
    trigger_edge = 2'b00;
    ack_capture("fall");

    // Auto timeout after 32 flat waiting samples, pre_trigger 0
    tick();
    pulse_start();
    for (int i = 0; i < 31; i++) send_sample(8'h10, 8'h10);
    chk("auto_early", 32'(send_data_rdy), 32'd0);
    exp_q.push_back('{addr: wa, tout: 1'b1});
    send_sample(8'h10, 8'h10);
    chk("auto_tout_flag", 32'(timed_out), 32'd1);
    finish_capture("auto");
    trigger_conf = 1'b0;
    ack_capture("auto");

    // Single mode: force ignored without request, no timeout, then forced capture
    tick();
    force_trigger = 1'b1;
    tick();
    force_trigger = 1'b0;
    for (int i = 0; i < 10; i++) send_sample(8'h10, 8'h10);
    chk("force_unarmed", 32'(send_data_rdy), 32'd0);
    pulse_start();
    for (int i = 0; i < 40; i++) send_sample(8'h10, 8'h10);
    chk("single_no_tout", 32'(send_data_rdy), 32'd0);
    exp_q.push_back('{addr: wa, tout: 1'b0});
    force_trigger = 1'b1;
    tick();
    force_trigger = 1'b0;
    for (int i = 0; i < 7; i++) begin
      send_sample(8'h10, 8'h10);
      if (i == 5) chk("force_post_early", 32'(send_data_rdy), 32'd0);
    end
    finish_capture("force");
    pulse_start();
    num_samples = 16'd16;
    pre_trigger = 16'd20;
    ack_capture("force");

    // Clamped pre_trigger 15, start from sending honoured, first armed sample ignored
    for (int i = 0; i < 15; i++) send_sample(8'h00, 8'h00);
    send_sample(8'h00, 8'h90);
    chk("first_armed", 32'(send_data_rdy), 32'd0);
    send_sample(8'h00, 8'h70);
    chk("clamp_no_early", 32'(send_data_rdy), 32'd0);
    exp_q.push_back('{addr: wa, tout: 1'b0});
    send_sample(8'h00, 8'h90);
    finish_capture("clamp");
    pre_trigger = 16'd4;
    ack_capture("clamp");

    // Reset in the middle of post-loading
    for (int i = 0; i < 4; i++) send_sample(8'h00, 8'h00);
    pulse_start();
    send_sample(8'h00, 8'h70);
    send_sample(8'h00, 8'h90);
    chk("abort_trig_addr", 32'(trig_addr), 32'(wa - 16'd1));
    send_sample(8'h00, 8'h90);
    chk("abort_we_post", 32'(write_enable), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    wa = '0;
    chk("abort_wr_addr", 32'(wr_addr), 32'd0);
    chk("abort_trig_rst", 32'(trig_addr), 32'd0);
    chk("abort_rdy", 32'(send_data_rdy), 32'd0);
    chk("abort_tout", 32'(timed_out), 32'd0);
    chk("abort_we", 32'(write_enable), 32'd1);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
